// File: rtl/ila_capture_engine_pkg.sv
// ila_capture_engine_pkg
// Shared definitions for the ILA capture engine: FSM state encoding, trigger
// mode codes, the trigger qualification helper and the readout width macro.
// Build option: ILA_TIMESTAMP_EN -- each stored/streamed word carries a
// free-running timestamp above the probe sample.
`ifndef ILA_CAPTURE_ENGINE_PKG_SV
`define ILA_CAPTURE_ENGINE_PKG_SV

`ifdef ILA_TIMESTAMP_EN
`define ILA_OUT_W(dw, tw) ((tw) + (dw))
`else
// tw stays in the expression so the timestamp width is referenced in both builds.
`define ILA_OUT_W(dw, tw) ((dw) + 0 * (tw))
`endif

package ila_capture_engine_pkg;

  typedef enum logic [2:0] {
    ST_FILL    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_STOPPED = 3'd3,
    ST_READ    = 3'd4,
    ST_DONE    = 3'd5
  } ila_state_e;

  localparam logic [1:0] TRIG_EXT = 2'd0;
  localparam logic [1:0] TRIG_PAT = 2'd1;
  localparam logic [1:0] TRIG_OR  = 2'd2;
  localparam logic [1:0] TRIG_AND = 2'd3;

  function automatic logic trig_qualify(input logic [1:0] mode,
                                        input logic       ext_hit,
                                        input logic       pat_hit);
    logic q;
    case (mode)
      TRIG_EXT: q = ext_hit;
      TRIG_PAT: q = pat_hit;
      TRIG_OR:  q = ext_hit | pat_hit;
      default:  q = ext_hit & pat_hit;
    endcase
    return q;
  endfunction

endpackage

`endif

// File: rtl/ila_sample_ram.sv
// ila_sample_ram
// Simple dual-port sample buffer: one synchronous write port, one read port
// with a registered output (read latency 1). No reset on the array so it maps
// onto block RAM.
// Ports:
//   clk      clock
//   i_we     write enable          i_waddr / i_wdata  write address / data
//   i_re     read enable           i_raddr            read address
//   o_rdata  registered read data (valid the cycle after i_re)
module ila_sample_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/ila_capture_engine.sv
// ila_capture_engine
// Circular-buffer capture core of the internal logic analyzer. Writes one probe
// sample per cycle, triggers on an external pulse and/or masked pattern, runs a
// holdoff, freezes, then streams the buffer oldest-first over valid/ready.
// Build option: ILA_TIMESTAMP_EN -- stores {timestamp, sample} per entry.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_data                     probe bus
//   i_trigger                  external trigger pulse
//   i_trig_mask/i_trig_value   pattern compare (mask bit 1 = care)
//   i_trig_mode                0 ext, 1 pattern, 2 ext|pattern, 3 ext&pattern
//   i_holdoff                  samples written after the trigger sample
//   i_rearm                    restart capture from STOPPED/READ/DONE
//   o_data/o_valid/o_last      readout stream, i_ready from host
//   o_primed/o_triggered/o_stopped/o_trig_addr   capture status
//
// state   | meaning
// FILL    | writing, buffer not yet filled once since arm
// ARMED   | writing, trigger qualification active
// HOLDOFF | writing the post-trigger samples
// STOPPED | writing frozen, first read issued
// READ    | streaming the buffer oldest-first
// DONE    | stream finished, waiting for rearm
module ila_capture_engine
  import ila_capture_engine_pkg::*;
#(
  parameter int  DATA_WIDTH    = 32,
  parameter int  ADDR_WIDTH    = 10,
  parameter int  HOLDOFF_WIDTH = 10,
  parameter int  TS_WIDTH      = 16,
  localparam int OUT_W         = `ILA_OUT_W(DATA_WIDTH, TS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_trigger,
  input  logic [DATA_WIDTH-1:0]    i_trig_mask,
  input  logic [DATA_WIDTH-1:0]    i_trig_value,
  input  logic [1:0]               i_trig_mode,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rearm,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  ila_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  primed_q, primed_d;
  logic                  triggered_q, triggered_d;
  logic                  stopped_q, stopped_d;
  logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  out_v_q, out_v_d;
  logic                  out_last_q, out_last_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;
  logic                  skid_v_q, skid_v_d;
  logic                  skid_last_q, skid_last_d;
  logic [OUT_W-1:0]      skid_data_q, skid_data_d;

  logic                  wr_en;
  logic [OUT_W-1:0]      wr_data;
  logic                  rd_issue;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [OUT_W-1:0]      ram_rdata;
  logic                  pat_hit;
  logic                  trig_hit;
  logic [ADDR_WIDTH-1:0] holdoff_eff;
  logic                  pop;
  logic [1:0]            held_after;

`ifdef ILA_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  assign ts_d    = ts_q + 1'b1;
  assign wr_data = {ts_q, i_data};
`else
  assign wr_data = i_data;
`endif

  assign wr_en    = (state_q == ST_FILL) || (state_q == ST_ARMED) || (state_q == ST_HOLDOFF);
  assign pat_hit  = ((i_data ^ i_trig_value) & i_trig_mask) == '0;
  assign trig_hit = (state_q == ST_ARMED) && trig_qualify(i_trig_mode, i_trigger, pat_hit);

  // A holdoff of a full buffer or more would overwrite the trigger sample.
  assign holdoff_eff = (32'(i_holdoff) > 32'(ADDR_MAX)) ? ADDR_MAX : ADDR_WIDTH'(i_holdoff);

  // Readout holds up to two words (output + skid). A read is issued only when
  // the words still held after this cycle's pop leave room for its return.
  assign pop        = out_v_q & i_ready;
  assign held_after = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q) - 2'(pop);
  assign rd_issue   = ((state_q == ST_STOPPED) || (state_q == ST_READ)) &&
                      !rd_cnt_q[ADDR_WIDTH] && (held_after <= 2'd1);
  // The frozen write pointer is the oldest sample.
  assign raddr      = waddr_q + rd_cnt_q[ADDR_WIDTH-1:0];

  ila_sample_ram #(
    .WIDTH      (OUT_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (wr_en),
    .i_waddr (waddr_q),
    .i_wdata (wr_data),
    .i_re    (rd_issue),
    .i_raddr (raddr),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = wr_en ? waddr_q + 1'b1 : waddr_q;
    hold_cnt_d  = hold_cnt_q;
    trig_addr_d = trig_addr_q;
    primed_d    = primed_q;
    triggered_d = triggered_q;
    stopped_d   = stopped_q;
    rd_cnt_d    = rd_issue ? rd_cnt_q + 1'b1 : rd_cnt_q;
    pend_d      = rd_issue;
    pend_last_d = rd_issue && (rd_cnt_q[ADDR_WIDTH-1:0] == ADDR_MAX);
    out_v_d     = out_v_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_v_d    = skid_v_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;

    case (state_q)
      ST_FILL: begin
        if (waddr_q == ADDR_MAX) begin
          state_d  = ST_ARMED;
          primed_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (trig_hit) begin
          trig_addr_d = waddr_q;
          triggered_d = 1'b1;
          if (holdoff_eff == '0) begin
            state_d   = ST_STOPPED;
            stopped_d = 1'b1;
          end else begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = holdoff_eff;
          end
        end
      end
      ST_HOLDOFF: begin
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q == ADDR_WIDTH'(1)) begin
          state_d   = ST_STOPPED;
          stopped_d = 1'b1;
        end
      end
      ST_STOPPED: state_d = ST_READ;
      ST_READ: begin
        if (pop && out_last_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_FILL;
    endcase

    // Output register refills from skid first, then straight from the RAM.
    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_v_d     = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_v_d    = pend_q;
        skid_data_d = ram_rdata;
        skid_last_d = pend_last_q;
      end else if (pend_q) begin
        out_v_d    = 1'b1;
        out_data_d = ram_rdata;
        out_last_d = pend_last_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (pend_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = ram_rdata;
      skid_last_d = pend_last_q;
    end

    // Rearm overrides any handshake in the same cycle and drops the stream.
    if (i_rearm && ((state_q == ST_STOPPED) || (state_q == ST_READ) || (state_q == ST_DONE))) begin
      state_d     = ST_FILL;
      waddr_d     = '0;
      hold_cnt_d  = '0;
      trig_addr_d = '0;
      primed_d    = 1'b0;
      triggered_d = 1'b0;
      stopped_d   = 1'b0;
      rd_cnt_d    = '0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      out_v_d     = 1'b0;
      out_last_d  = 1'b0;
      skid_v_d    = 1'b0;
      skid_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      waddr_q     <= '0;
      hold_cnt_q  <= '0;
      trig_addr_q <= '0;
      primed_q    <= 1'b0;
      triggered_q <= 1'b0;
      stopped_q   <= 1'b0;
      rd_cnt_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      out_v_q     <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
`ifdef ILA_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      hold_cnt_q  <= hold_cnt_d;
      trig_addr_q <= trig_addr_d;
      primed_q    <= primed_d;
      triggered_q <= triggered_d;
      stopped_q   <= stopped_d;
      rd_cnt_q    <= rd_cnt_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      out_v_q     <= out_v_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_v_q    <= skid_v_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
`ifdef ILA_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  assign o_data      = out_data_q;
  assign o_valid     = out_v_q;
  assign o_last      = out_last_q;
  assign o_primed    = primed_q;
  assign o_triggered = triggered_q;
  assign o_stopped   = stopped_q;
  assign o_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_ila_capture_engine.sv
// tb_ila_capture_engine
// Directed capture scenarios with randomized data and backpressure. Expected
// readout is derived from the sample history the bench drove: the trigger is
// the first qualifying sample once the buffer has filled, and the capture is
// the DEPTH samples ending holdoff (clamped) samples after it.
module tb_ila_capture_engine;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 4;
  localparam int HOLDOFF_WIDTH = 10;
  localparam int TS_WIDTH      = 16;
  localparam int DEPTH         = 1 << ADDR_WIDTH;
  localparam int MAXN          = 256;
`ifdef ILA_TIMESTAMP_EN
  localparam int OUT_W = TS_WIDTH + DATA_WIDTH;
`else
  localparam int OUT_W = DATA_WIDTH;
`endif

  logic                     clk;
  logic                     reset;
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_trigger;
  logic [DATA_WIDTH-1:0]    i_trig_mask;
  logic [DATA_WIDTH-1:0]    i_trig_value;
  logic [1:0]               i_trig_mode;
  logic [HOLDOFF_WIDTH-1:0] i_holdoff;
  logic                     i_rearm;
  logic [OUT_W-1:0]         o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_last;
  logic                     o_primed;
  logic                     o_triggered;
  logic                     o_stopped;
  logic [ADDR_WIDTH-1:0]    o_trig_addr;

  int checks   = 0;
  int failures = 0;

  logic [DATA_WIDTH-1:0] data_a [0:MAXN-1];
  logic                  ext_a  [0:MAXN-1];

  ila_capture_engine #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .HOLDOFF_WIDTH (HOLDOFF_WIDTH),
    .TS_WIDTH      (TS_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_data       (i_data),
    .i_trigger    (i_trigger),
    .i_trig_mask  (i_trig_mask),
    .i_trig_value (i_trig_value),
    .i_trig_mode  (i_trig_mode),
    .i_holdoff    (i_holdoff),
    .i_rearm      (i_rearm),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_primed     (o_primed),
    .o_triggered  (o_triggered),
    .o_stopped    (o_stopped),
    .o_trig_addr  (o_trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit qual(input int mode, input bit ext, input logic [31:0] d,
                              input logic [31:0] mask, input logic [31:0] value);
    bit pat;
    pat = ((d & mask) == (value & mask));
    case (mode)
      0:       return ext;
      1:       return pat;
      2:       return ext || pat;
      default: return ext && pat;
    endcase
  endfunction

  task automatic fill(input bit ramp);
    for (int i = 0; i < MAXN; i++) begin
      data_a[i] = ramp ? 32'(i) : $urandom;
      ext_a[i]  = 1'b0;
    end
  endtask

  // Runs one capture from a freshly armed (FILL, address 0) engine.
  // abort_at >= 0 rearms on the same cycle word abort_at is handshaken.
  task automatic do_capture(input int mode, input int hold, input logic [31:0] mask,
                            input logic [31:0] value, input int ready_pct, input int abort_at);
    int t, h, n, c, k, first_c, last_c;
    bit stopped_seen;
`ifdef ILA_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] prev_ts;
    prev_ts = '0;
`endif
    t = -1;
    for (int i = DEPTH; i < MAXN; i++)
      if (t < 0 && qual(mode, ext_a[i], data_a[i], mask, value)) t = i;
    h = (hold > DEPTH - 1) ? DEPTH - 1 : hold;
    i_trig_mode  = 2'(mode);
    i_holdoff    = HOLDOFF_WIDTH'(hold);
    i_trig_mask  = mask;
    i_trig_value = value;
    stopped_seen = 1'b0;
    for (n = 0; n < MAXN && !stopped_seen; n++) begin
      i_data    = data_a[n];
      i_trigger = ext_a[n];
      step();
      if (n == DEPTH - 2 || n == DEPTH - 1) check("primed_edge", o_primed, n == DEPTH - 1);
      if (o_stopped) begin
        stopped_seen = 1'b1;
        check("stop_sample", n, t + h);
      end
    end
    check("stop_seen", stopped_seen, 1);
    if (!stopped_seen) return;
    check("trig_addr", o_trig_addr, t % DEPTH);
    check("triggered", o_triggered, 1);
    c = 0; k = 0; first_c = -1; last_c = -1;
    while (k < DEPTH && c < 400) begin
      i_data    = $urandom;
      i_trigger = ($urandom_range(3) == 0);
      i_ready   = ($urandom_range(99) < ready_pct);
      if (o_valid) begin
        if (first_c < 0) begin
          first_c = c;
          check("first_valid_latency", c, 2);
        end
        check("rd_data", o_data[DATA_WIDTH-1:0], data_a[t + h - (DEPTH - 1) + k]);
        check("rd_last", o_last, k == DEPTH - 1);
        if (i_ready) begin
`ifdef ILA_TIMESTAMP_EN
          if (k > 0) check("ts_step", o_data[OUT_W-1:DATA_WIDTH], prev_ts + 1'b1);
          prev_ts = o_data[OUT_W-1:DATA_WIDTH];
`endif
          if (k == abort_at) i_rearm = 1'b1;
          last_c = c;
          k++;
        end
      end
      step();
      c++;
      if (i_rearm) begin
        i_rearm = 1'b0;
        check("abort_valid", o_valid, 0);
        check("abort_primed", o_primed, 0);
        check("abort_stopped", o_stopped, 0);
        check("abort_triggered", o_triggered, 0);
        return;
      end
    end
    check("readout_count", k, DEPTH);
    if (ready_pct == 100) check("throughput", last_c - first_c, DEPTH - 1);
    repeat (3) begin
      step();
      check("done_idle", o_valid, 0);
    end
    check("done_frozen", o_stopped, 1);
    i_rearm = 1'b1;
    step();
    i_rearm = 1'b0;
    check("rearm_primed", o_primed, 0);
    check("rearm_stopped", o_stopped, 0);
    check("rearm_triggered", o_triggered, 0);
  endtask

  initial begin
    reset = 1'b1; i_data = '0; i_trigger = 1'b0; i_trig_mask = '0; i_trig_value = '0;
    i_trig_mode = '0; i_holdoff = '0; i_rearm = 1'b0; i_ready = 1'b1;
    repeat (3) step();
    check("rst_primed", o_primed, 0);
    check("rst_triggered", o_triggered, 0);
    check("rst_stopped", o_stopped, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_data", o_data, 0);
    check("rst_trig_addr", o_trig_addr, 0);
    reset = 1'b0;

    // Ramp, ext trigger at 20 (8 is pre-prime, 22 lands in holdoff), holdoff 5.
    fill(1'b1);
    ext_a[8] = 1'b1; ext_a[20] = 1'b1; ext_a[22] = 1'b1;
    do_capture(0, 5, 32'h0, 32'h0, 100, -1);

    // Pre-prime ext pulse ignored, then pattern 0x30 on the low byte.
    fill(1'b1);
    ext_a[8] = 1'b1;
    do_capture(2, 3, 32'hFF, 32'h30, 100, -1);

    // ext & pattern: non-coincident events rejected, coincident accepted.
    fill(1'b0);
    ext_a[20] = 1'b1; data_a[20] = 32'h0;
    data_a[25] = 32'h0000_5050;
    ext_a[30] = 1'b1; data_a[30] = 32'h1234_5A5F;
    do_capture(3, 2, 32'hF0F0, 32'h5050, 70, -1);

    // Oversized holdoff clamps so the trigger sample is read first.
    fill(1'b0);
    ext_a[17] = 1'b1;
    do_capture(0, 100, 32'h0, 32'h0, 100, -1);

    // Pattern trigger with random holdoff under random backpressure.
    fill(1'b0);
    data_a[40][15:8] = 8'hA5;
    do_capture(1, int'($urandom_range(20)), 32'h0000_FF00, 32'h0000_A500, 50, -1);

    // Rearm coincident with a handshake in the middle of the stream.
    fill(1'b0);
    ext_a[19] = 1'b1;
    do_capture(0, 4, 32'h0, 32'h0, 100, 5);

    // Reset while in holdoff.
    fill(1'b1);
    ext_a[18] = 1'b1;
    i_trig_mode = 2'd0; i_holdoff = HOLDOFF_WIDTH'(10);
    for (int n = 0; n <= 20; n++) begin
      i_data = data_a[n]; i_trigger = ext_a[n];
      step();
    end
    check("holdoff_triggered", o_triggered, 1);
    check("holdoff_not_stopped", o_stopped, 0);
    reset = 1'b1;
    step();
    check("rst2_primed", o_primed, 0);
    check("rst2_triggered", o_triggered, 0);
    check("rst2_stopped", o_stopped, 0);
    check("rst2_trig_addr", o_trig_addr, 0);
    reset = 1'b0;

    // Fresh capture after reset: holdoff 0 at the first armed sample.
    fill(1'b1);
    ext_a[16] = 1'b1;
    do_capture(0, 0, 32'h0, 32'h0, 100, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
